bridge_arbiter: RTL and testbench

- Shares one bridge (C_in_valid / C_out_valid command port) between N_REQ requesters, one transaction outstanding at a time.
- Round-robin arbitration, with an optional fixed-priority mode.
- Sits between the client blocks and the bridge, and sequences each command through the bridge.
- Routes the bridge's read data or write response back to the requester that owns the transaction.

---
 rtl/bridge_arbiter.sv | 166 ++++++++++++++++
 tb/tb_bridge_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bridge_arbiter.sv
// -----------------------------------------------------------------------------
// bridge_arbiter
//
// Purpose:
//   Shares one command bridge between N_REQ requesters, with at most one
//   transaction in flight. A requester is accepted in IDLE. The command is
//   then presented to the bridge for one cycle (ISSUE). The arbiter waits
//   for the bridge completion (WAIT) and routes the result back to the
//   requester that owns the transaction.
//
// Configuration:
//   BRIDGE_ARB_FIXED_PRIO_EN - when defined, the lowest index always wins and
//   there is no rotating pointer. When undefined (default), arbitration is
//   round-robin.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req_valid       per-requester request, held until accepted
//   req_r_wb        per-requester op (1 = read, 0 = write)
//   req_addr        packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data_w      packed write data, requester i at [i*DATA_W +: DATA_W]
//   req_ready       one-hot accept strobe (combinational, IDLE only)
//   rsp_valid       one-hot one-cycle completion pulse to the owner
//   rsp_data        result of the last completion, held until the next one
//   busy            a transaction is in flight
//   C_in_valid      command strobe to bridge
//   C_r_wb, C_addr, C_data_w  command fields to bridge
//   C_out_valid     completion from bridge
//   C_data_r        result from bridge, valid with C_out_valid
// -----------------------------------------------------------------------------
module bridge_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_r_wb,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_data_w,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      busy,
    output logic                      C_in_valid,
    output logic                      C_r_wb,
    output logic [ADDR_W-1:0]         C_addr,
    output logic [DATA_W-1:0]         C_data_w,
    input  logic                      C_out_valid,
    input  logic [DATA_W-1:0]         C_data_r
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [PTR_W-1:0]   w_rr_ptr;
    logic [PTR_W-1:0]   r_owner;
    logic [PTR_W-1:0]   w_winner;
    logic               w_found;
    logic               w_grant;
    logic               w_complete;
    logic [N_REQ-1:0]   r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_data;
    logic               r_c_in_valid;
    logic               r_c_r_wb;
    logic [ADDR_W-1:0]  r_c_addr;
    logic [DATA_W-1:0]  r_c_data_w;

`ifdef BRIDGE_ARB_FIXED_PRIO_EN
    // Scanning always starts at requester 0, so the lowest index wins.
    assign w_rr_ptr = '0;
`else
    logic [PTR_W-1:0]   r_rr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_grant) begin
            r_rr_ptr <= PTR_W'((int'(w_winner) + 1) % N_REQ);
        end
    end

    assign w_rr_ptr = r_rr_ptr;
`endif

    // First active requester scanning upward from the pointer, with wrap.
    always_comb begin
        int w_idx;
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = (int'(w_rr_ptr) + k) % N_REQ;
            if (!w_found && req_valid[w_idx[PTR_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[PTR_W-1:0];
            end
        end
    end

    assign w_grant    = (r_state == IDLE) && w_found;
    assign w_complete = (r_state == WAIT) && C_out_valid;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_found) w_state_next = ISSUE;
            ISSUE:   w_state_next = WAIT;
            WAIT:    if (C_out_valid) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner      <= '0;
            r_rsp_valid  <= '0;
            r_rsp_data   <= '0;
            r_c_in_valid <= 1'b0;
            r_c_r_wb     <= 1'b0;
            r_c_addr     <= '0;
            r_c_data_w   <= '0;
        end else begin
            // Strobe is high only in the cycle after a grant, i.e. in ISSUE.
            r_c_in_valid <= w_grant;
            r_rsp_valid  <= '0;
            if (w_grant) begin
                r_owner    <= w_winner;
                r_c_r_wb   <= req_r_wb[w_winner];
                r_c_addr   <= req_addr[int'(w_winner)*ADDR_W +: ADDR_W];
                r_c_data_w <= req_data_w[int'(w_winner)*DATA_W +: DATA_W];
            end
            // Completions outside WAIT are ignored.
            if (w_complete) begin
                r_rsp_data  <= C_data_r;
                r_rsp_valid <= N_REQ'(1) << r_owner;
            end
        end
    end

    assign req_ready  = w_grant ? (N_REQ'(1) << w_winner) : '0;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign busy       = (r_state != IDLE);
    assign C_in_valid = r_c_in_valid;
    assign C_r_wb     = r_c_r_wb;
    assign C_addr     = r_c_addr;
    assign C_data_w   = r_c_data_w;

endmodule

// File: tb/tb_bridge_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bridge_arbiter
//
// Directed testbench for bridge_arbiter (N_REQ=4, ADDR_W=8, DATA_W=32).
// The bridge side is driven directly by each scenario task. Inputs change
// 1 ns after the rising edge and outputs are sampled 1-2 ns after it.
// Honours BRIDGE_ARB_FIXED_PRIO_EN for the expected grant order.
// -----------------------------------------------------------------------------
module tb_bridge_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_r_wb;
    logic [31:0]  req_addr;
    logic [127:0] req_data_w;
    logic [3:0]   req_ready;
    logic [3:0]   rsp_valid;
    logic [31:0]  rsp_data;
    logic         busy;
    logic         C_in_valid;
    logic         C_r_wb;
    logic [7:0]   C_addr;
    logic [31:0]  C_data_w;
    logic         C_out_valid;
    logic [31:0]  C_data_r;

    int checks;
    int failures;

    bridge_arbiter #(.N_REQ(4), .ADDR_W(8), .DATA_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_r_wb    (req_r_wb),
        .req_addr    (req_addr),
        .req_data_w  (req_data_w),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .busy        (busy),
        .C_in_valid  (C_in_valid),
        .C_r_wb      (C_r_wb),
        .C_addr      (C_addr),
        .C_data_w    (C_data_w),
        .C_out_valid (C_out_valid),
        .C_data_r    (C_data_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 4'b0;
        C_out_valid = 1'b0;
        step();
        checks++;
        if ({req_ready, rsp_valid, busy, C_in_valid, C_r_wb} !== 11'b0) begin
            failures++;
            $display("FAIL reset_ctrl act=%b exp=0", {req_ready, rsp_valid, busy, C_in_valid, C_r_wb});
        end
        checks++;
        if ({rsp_data, C_addr, C_data_w} !== 72'b0) begin
            failures++;
            $display("FAIL reset_data act=%h exp=0", {rsp_data, C_addr, C_data_w});
        end
        rst_n = 1'b1;
        step();
        $display("reset: done");
    endtask

    task automatic test_single_read();
        req_r_wb = 4'b0001;
        req_addr = 32'h0000003C;
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++; $display("FAIL rd_ready act=%b exp=0001", req_ready);
        end
        step();                      // ISSUE
        req_valid = 4'b0;
        checks++;
        if ({C_in_valid, C_r_wb, C_addr, busy} !== {1'b1, 1'b1, 8'h3C, 1'b1}) begin
            failures++;
            $display("FAIL rd_issue act=in%b rwb%b addr%h busy%b exp=in1 rwb1 addr3c busy1",
                     C_in_valid, C_r_wb, C_addr, busy);
        end
        step();                      // WAIT
        checks++;
        if ({C_in_valid, busy} !== 2'b01) begin
            failures++; $display("FAIL rd_wait act=in%b busy%b exp=in0 busy1", C_in_valid, busy);
        end
        step();                      // still WAIT
        C_out_valid = 1'b1;
        C_data_r = 32'hDEADBEEF;
        step();                      // IDLE with response
        C_out_valid = 1'b0;
        checks++;
        if ({rsp_valid, rsp_data, busy} !== {4'b0001, 32'hDEADBEEF, 1'b0}) begin
            failures++;
            $display("FAIL rd_rsp act=v%b d%h busy%b exp=v0001 ddeadbeef busy0", rsp_valid, rsp_data, busy);
        end
        step();
        checks++;
        if ({rsp_valid, rsp_data} !== {4'b0000, 32'hDEADBEEF}) begin
            failures++; $display("FAIL rd_pulse act=v%b d%h exp=v0000 ddeadbeef", rsp_valid, rsp_data);
        end
        $display("single_read: addr=3c data=%h", rsp_data);
    endtask

    task automatic test_single_write();
        req_r_wb = 4'b1011;
        req_addr = 32'h11052233;
        req_data_w = {32'hAAAAAAAA, 32'h12345678, 32'hBBBBBBBB, 32'hCCCCCCCC};
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++; $display("FAIL wr_ready act=%b exp=0100", req_ready);
        end
        step();                      // ISSUE
        req_valid = 4'b0;
        checks++;
        if ({C_in_valid, C_r_wb, C_addr, C_data_w} !== {1'b1, 1'b0, 8'h05, 32'h12345678}) begin
            failures++;
            $display("FAIL wr_issue act=in%b rwb%b addr%h dw%h exp=in1 rwb0 addr05 dw12345678",
                     C_in_valid, C_r_wb, C_addr, C_data_w);
        end
        step();                      // WAIT
        C_out_valid = 1'b1;
        C_data_r = 32'h0;
        step();
        C_out_valid = 1'b0;
        checks++;
        if ({rsp_valid, rsp_data} !== {4'b0100, 32'h0}) begin
            failures++; $display("FAIL wr_rsp act=v%b d%h exp=v0100 d0", rsp_valid, rsp_data);
        end
        step();
        $display("single_write: addr=05 data=12345678");
    endtask

    task automatic test_round_robin();
        int cnt [4];
        int exp_cnt [4];
        logic [3:0] exp_g;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        req_r_wb = 4'b1111;
        req_addr = 32'h13121110;
        req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 8; k++) begin
`ifdef BRIDGE_ARB_FIXED_PRIO_EN
            exp_g = 4'b0001;
`else
            exp_g = 4'b0001 << (k % 4);
`endif
            checks++;
            if (req_ready !== exp_g) begin
                failures++; $display("FAIL rr_grant%0d act=%b exp=%b", k, req_ready, exp_g);
            end
            step();                  // ISSUE
            step();                  // WAIT
            C_out_valid = 1'b1;
            C_data_r = 32'h100 + k;
            step();                  // IDLE
            C_out_valid = 1'b0;
            for (int i = 0; i < 4; i++) if (rsp_valid[i]) cnt[i]++;
            $display("round_robin: txn=%0d grant=%b rsp=%b", k, exp_g, rsp_valid);
        end
        req_valid = 4'b0;
`ifdef BRIDGE_ARB_FIXED_PRIO_EN
        exp_cnt = '{8, 0, 0, 0};
`else
        exp_cnt = '{2, 2, 2, 2};
`endif
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cnt[i] != exp_cnt[i]) begin
                failures++; $display("FAIL rr_count%0d act=%0d exp=%0d", i, cnt[i], exp_cnt[i]);
            end
        end
        step();
    endtask

    task automatic test_late_arrival();
        req_r_wb = 4'b1111;
        req_addr = 32'h33221100;
        req_valid = 4'b1000;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++; $display("FAIL late_g3 act=%b exp=1000", req_ready);
        end
        step();                      // ISSUE
        req_valid = 4'b0;
        step();                      // WAIT
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++; $display("FAIL late_hold act=%b exp=0000", req_ready);
        end
        step();
        C_out_valid = 1'b1;
        C_data_r = 32'h33;
        step();                      // IDLE: response to 3, grant to 1
        C_out_valid = 1'b0;
        checks++;
        if ({rsp_valid, req_ready} !== {4'b1000, 4'b0010}) begin
            failures++; $display("FAIL late_same act=rsp%b rdy%b exp=rsp1000 rdy0010", rsp_valid, req_ready);
        end
        step();                      // ISSUE for 1
        req_valid = 4'b0;
        checks++;
        if ({C_in_valid, C_addr} !== {1'b1, 8'h11}) begin
            failures++; $display("FAIL late_issue act=in%b addr%h exp=in1 addr11", C_in_valid, C_addr);
        end
        step();
        C_out_valid = 1'b1;
        C_data_r = 32'h11;
        step();
        C_out_valid = 1'b0;
        checks++;
        if (rsp_valid !== 4'b0010) begin
            failures++; $display("FAIL late_rsp1 act=%b exp=0010", rsp_valid);
        end
        step();
        $display("late_arrival: grants 3 then 1");
    endtask

    task automatic test_spurious();
        C_out_valid = 1'b1;          // in IDLE
        C_data_r = 32'hBAD0BAD0;
        step();
        C_out_valid = 1'b0;
        checks++;
        if ({rsp_valid, busy, rsp_data} !== {4'b0, 1'b0, 32'h11}) begin
            failures++; $display("FAIL spur_idle act=v%b busy%b d%h exp=v0000 busy0 d11", rsp_valid, busy, rsp_data);
        end
        req_valid = 4'b0001;
        step();                      // ISSUE
        req_valid = 4'b0;
        C_out_valid = 1'b1;          // in ISSUE
        step();                      // WAIT
        C_out_valid = 1'b0;
        checks++;
        if ({rsp_valid, busy} !== {4'b0, 1'b1}) begin
            failures++; $display("FAIL spur_issue act=v%b busy%b exp=v0000 busy1", rsp_valid, busy);
        end
        step();
        C_out_valid = 1'b1;
        C_data_r = 32'hA5A5A5A5;
        step();
        C_out_valid = 1'b0;
        checks++;
        if ({rsp_valid, rsp_data} !== {4'b0001, 32'hA5A5A5A5}) begin
            failures++; $display("FAIL spur_real act=v%b d%h exp=v0001 da5a5a5a5", rsp_valid, rsp_data);
        end
        step();
        $display("spurious: real data=%h", rsp_data);
    endtask

    task automatic test_reset_in_wait();
        req_valid = 4'b0010;
        step();                      // ISSUE
        req_valid = 4'b0;
        step();                      // WAIT
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, busy, C_in_valid, C_r_wb, C_addr, C_data_w, rsp_data} !== 83'b0) begin
            failures++;
            $display("FAIL rstw_async act=busy%b rwb%b addr%h d%h exp=0",
                     busy, C_r_wb, C_addr, rsp_data);
        end
        step();
        rst_n = 1'b1;
        C_out_valid = 1'b1;          // late bridge completion must be dropped
        C_data_r = 32'h77777777;
        step();
        C_out_valid = 1'b0;
        step();
        checks++;
        if ({rsp_valid, busy} !== 5'b0) begin
            failures++; $display("FAIL rstw_norsp act=v%b busy%b exp=v0000 busy0", rsp_valid, busy);
        end
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++; $display("FAIL rstw_ptr act=%b exp=0001", req_ready);
        end
        step();
        req_valid = 4'b0;
        step();
        $display("reset_in_wait: next grant=0001");
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        req_valid = 4'b0;
        req_r_wb = 4'b0;
        req_addr = 32'b0;
        req_data_w = 128'b0;
        C_out_valid = 1'b0;
        C_data_r = 32'b0;
        test_reset();
        test_single_read();
        test_single_write();
        test_reset();
        test_round_robin();
        test_late_arrival();
        test_spurious();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
